// File: rtl/safe_lock_ctrl.sv
// safe_lock_ctrl: shifts keypad code words MSB-first into the serial unlock detector,
// drives the unlock window and the failure lockout. Define SAFE_CTRL_EARLY_RELOCK_EN for the relock input.
module safe_lock_ctrl #(
  parameter int CODE_BITS      = 4,
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 500,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           code_valid,
  output logic                           code_ready,
  input  logic [CODE_BITS-1:0]           code_data,
  output logic                           det_rstn,
  output logic                           ser_val,
  output logic                           ser_data,
  input  logic                           det_val,
  input  logic                           det_data,
  output logic                           unlock,
  output logic                           locked_out,
`ifdef SAFE_CTRL_EARLY_RELOCK_EN
  input  logic                           relock,
`endif
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

  // Handshake: a code word is taken on a rising edge where code_valid and code_ready
  // are both high; code_ready is high only in IDLE and nothing is queued otherwise.

  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int BW   = (CODE_BITS > 1) ? $clog2(CODE_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_FLUSH,
    S_OPEN,
    S_LOCKOUT
  } state_t;

  state_t               state_q;
  logic                 boot_q;
  logic [CODE_BITS-1:0] sr_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [TW-1:0]        timer_q;
  logic                 hit_q;
  logic                 ready_q;
  logic                 det_rstn_q;
  logic                 ser_val_q;
  logic                 ser_data_q;
  logic                 unlock_q;
  logic                 locked_q;
  logic [FW-1:0]        fail_q;
  logic                 early_relock;

`ifdef SAFE_CTRL_EARLY_RELOCK_EN
  assign early_relock = relock;
`else
  assign early_relock = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      boot_q     <= 1'b0;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      timer_q    <= '0;
      hit_q      <= 1'b0;
      ready_q    <= 1'b0;
      det_rstn_q <= 1'b0;
      ser_val_q  <= 1'b0;
      ser_data_q <= 1'b0;
      unlock_q   <= 1'b0;
      locked_q   <= 1'b0;
      fail_q     <= '0;
    end else begin
      boot_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          ready_q    <= 1'b1;
          // Holds the detector in reset for one extra cycle after rstn releases.
          det_rstn_q <= boot_q;
          if (code_valid && ready_q) begin
            state_q    <= S_SHIFT;
            ready_q    <= 1'b0;
            det_rstn_q <= 1'b1;
            sr_q       <= code_data << 1;
            ser_val_q  <= 1'b1;
            ser_data_q <= code_data[CODE_BITS-1];
            bit_cnt_q  <= '0;
          end
        end
        S_SHIFT: begin
          if (bit_cnt_q == BW'(CODE_BITS - 1)) begin
            // Mealy verdict on the last bit is the only one that counts.
            hit_q      <= det_val & det_data;
            state_q    <= S_FLUSH;
            ser_val_q  <= 1'b0;
            ser_data_q <= 1'b0;
            det_rstn_q <= 1'b0;
          end else begin
            ser_data_q <= sr_q[CODE_BITS-1];
            sr_q       <= sr_q << 1;
            bit_cnt_q  <= bit_cnt_q + BW'(1);
          end
        end
        S_FLUSH: begin
          det_rstn_q <= 1'b1;
          if (hit_q) begin
            fail_q   <= '0;
            timer_q  <= TW'(UNLOCK_CYCLES);
            unlock_q <= 1'b1;
            state_q  <= S_OPEN;
          end else if (int'(fail_q) + 1 >= MAX_FAILS) begin
            fail_q   <= FW'(MAX_FAILS);
            timer_q  <= TW'(LOCKOUT_CYCLES);
            locked_q <= 1'b1;
            state_q  <= S_LOCKOUT;
          end else begin
            fail_q  <= fail_q + FW'(1);
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_OPEN: begin
          if (timer_q == TW'(1) || early_relock) begin
            unlock_q <= 1'b0;
            ready_q  <= 1'b1;
            timer_q  <= '0;
            state_q  <= S_IDLE;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_LOCKOUT: begin
          if (timer_q == TW'(1)) begin
            locked_q <= 1'b0;
            fail_q   <= '0;
            ready_q  <= 1'b1;
            timer_q  <= '0;
            state_q  <= S_IDLE;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign code_ready = ready_q;
  assign det_rstn   = det_rstn_q;
  assign ser_val    = ser_val_q;
  assign ser_data   = ser_data_q;
  assign unlock     = unlock_q;
  assign locked_out = locked_q;
  assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Bench for safe_lock_ctrl with a behavioural 1011 Mealy detector and an attempt-level model
// of unlock, failure counting and lockout.
module tb_safe_lock_ctrl;

  localparam int CB = 4;
  localparam int MF = 3;
  localparam int UC = 8;
  localparam int LC = 20;
  localparam logic [3:0] SECRET = 4'b1011;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       code_valid = 1'b0;
  logic       code_ready;
  logic [3:0] code_data = '0;
  logic       det_rstn;
  logic       ser_val;
  logic       ser_data;
  logic       det_val;
  logic       det_data;
  logic       unlock;
  logic       locked_out;
  logic [1:0] fail_cnt;
`ifdef SAFE_CTRL_EARLY_RELOCK_EN
  logic       relock = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int exp_fail = 0;
  int hs_cnt = 0;
  logic [2:0] hist = '0;

  always #5 clk = ~clk;

  safe_lock_ctrl #(
    .CODE_BITS(CB), .MAX_FAILS(MF), .UNLOCK_CYCLES(UC), .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk(clk), .rstn(rstn), .code_valid(code_valid), .code_ready(code_ready),
    .code_data(code_data), .det_rstn(det_rstn), .ser_val(ser_val), .ser_data(ser_data),
    .det_val(det_val), .det_data(det_data), .unlock(unlock), .locked_out(locked_out),
`ifdef SAFE_CTRL_EARLY_RELOCK_EN
    .relock(relock),
`endif
    .fail_cnt(fail_cnt)
  );

  // Serial detector: matches when the last three bits plus the current one read 1011.
  always @(posedge clk) begin
    if (!det_rstn) hist <= '0;
    else if (ser_val) hist <= {hist[1:0], ser_data};
  end
  assign det_val  = ser_val;
  assign det_data = ser_val && ({hist, ser_data} == SECRET);

  always @(posedge clk) begin
    if (rstn && code_valid && code_ready) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full attempt starting at a negedge; returns at the negedge where code_ready is back.
  task automatic attempt(input logic [3:0] code, input bit keep_valid, input int relock_at);
    int  n;
    int  cnt;
    int  exp_len;
    bit  hit;
    code_valid = 1'b1;
    code_data  = code;
    n = 0;
    while (code_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(n < 200), 1);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) code_valid = 1'b0;
    for (int i = 0; i < CB; i++) begin
      check("shift_ser_val", ser_val, 1);
      check("shift_ser_data", ser_data, code[CB-1-i]);
      check("shift_ready", code_ready, 0);
      check("shift_det_rstn", det_rstn, 1);
      @(negedge clk);
    end
    check("flush_ser_val", ser_val, 0);
    check("flush_det_rstn", det_rstn, 0);
    check("flush_ready", code_ready, 0);
    @(negedge clk);
    hit = (code == SECRET);
    if (hit || exp_fail + 1 == MF) begin
      exp_fail = hit ? 0 : MF;
      exp_len  = hit ? ((relock_at > 0) ? relock_at : UC) : LC;
      check("win_fail_cnt", fail_cnt, exp_fail);
      check("win_ready", code_ready, 0);
      if (hit) check("win_locked_out", locked_out, 0);
      else     check("win_unlock", unlock, 0);
      cnt = 0;
      while ((hit ? unlock : locked_out) === 1'b1 && cnt < 100) begin
        cnt++;
`ifdef SAFE_CTRL_EARLY_RELOCK_EN
        if (cnt == relock_at) relock = 1'b1;
`endif
        @(negedge clk);
`ifdef SAFE_CTRL_EARLY_RELOCK_EN
        relock = 1'b0;
`endif
      end
      if (hit) check("unlock_len", cnt, exp_len);
      else     check("lockout_len", cnt, exp_len);
      exp_fail = 0;
    end else begin
      exp_fail++;
    end
    check("end_ready", code_ready, 1);
    check("end_fail_cnt", fail_cnt, exp_fail);
    check("end_unlock", unlock, 0);
    check("end_locked_out", locked_out, 0);
  endtask

  initial begin
    int n;
    int hs0;
    logic [3:0] c;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", code_ready, 0);
    check("rst_det_rstn", det_rstn, 0);
    check("rst_ser_val", ser_val, 0);
    check("rst_ser_data", ser_data, 0);
    check("rst_unlock", unlock, 0);
    check("rst_locked_out", locked_out, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("boot_ready", code_ready, 1);
    check("boot_det_rstn", det_rstn, 0);
    @(negedge clk);
    check("boot_det_rstn_rel", det_rstn, 1);

    // Correct code, then a single failure followed by a success
    attempt(SECRET, 1'b0, 0);
    attempt(4'b1001, 1'b0, 0);
    attempt(SECRET, 1'b0, 0);

    // Lockout with code_valid held high throughout
    hs0 = hs_cnt;
    attempt(4'b0000, 1'b1, 0);
    attempt(4'b0000, 1'b1, 0);
    attempt(4'b0000, 1'b1, 0);
    code_valid = 1'b0;
    @(negedge clk);
    check("lockout_handshakes", hs_cnt - hs0, 3);

    // Back-to-back correct codes
    hs0 = hs_cnt;
    attempt(SECRET, 1'b1, 0);
    attempt(SECRET, 1'b1, 0);
    attempt(SECRET, 1'b1, 0);
    code_valid = 1'b0;
    @(negedge clk);
    check("b2b_handshakes", hs_cnt - hs0, 3);

    // Reset on the second serial bit
    code_valid = 1'b1;
    code_data  = SECRET;
    n = 0;
    while (code_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    code_valid = 1'b0;
    @(negedge clk);
    check("midrst_bit2_val", ser_val, 1);
    check("midrst_bit2_data", ser_data, 0);
    #1 rstn = 1'b0;
    #1;
    check("midrst_ready", code_ready, 0);
    check("midrst_det_rstn", det_rstn, 0);
    check("midrst_ser_val", ser_val, 0);
    check("midrst_ser_data", ser_data, 0);
    check("midrst_unlock", unlock, 0);
    check("midrst_locked_out", locked_out, 0);
    check("midrst_fail_cnt", fail_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    exp_fail = 0;
    @(negedge clk);
    check("midrst_boot_ready", code_ready, 1);
    check("midrst_boot_det_rstn", det_rstn, 0);
    attempt(SECRET, 1'b0, 0);

`ifdef SAFE_CTRL_EARLY_RELOCK_EN
    // Early relock in the third open cycle
    attempt(SECRET, 1'b0, 3);
`endif

    // Randomized attempts with idle gaps
    for (int k = 0; k < 25; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      c = ($urandom_range(0, 2) == 0) ? SECRET : 4'($urandom_range(0, 15));
      attempt(c, 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
